// File: rtl/image_load_ctrl_if.sv
// Byte-stream, image RAM write port and inference handshake
// between the UART receiver, the load sequencer and the CNN engine.
interface image_load_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [7:0]        ram_wr_data;
    logic              ram_wr_en;
    logic              cnn_start;
    logic              cnn_done;
    logic              busy;
    logic              overrun;
    logic              timeout_err;
    logic [7:0]        frame_count;

    modport master (
        output rx_data,
        output rx_valid,
        output cnn_done,
        input  ram_wr_addr,
        input  ram_wr_data,
        input  ram_wr_en,
        input  cnn_start,
        input  busy,
        input  overrun,
        input  timeout_err,
        input  frame_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  cnn_done,
        output ram_wr_addr,
        output ram_wr_data,
        output ram_wr_en,
        output cnn_start,
        output busy,
        output overrun,
        output timeout_err,
        output frame_count
    );
endinterface

// File: rtl/image_load_ctrl.sv
// Frames the UART pixel stream behind a two-byte sync header, fills
// the image RAM, then launches one CNN inference per frame.
module image_load_ctrl #(
    parameter int          NUM_PIXELS     = 784,
    parameter int          ADDR_W         = 10,
    parameter logic [7:0]  SYNC0          = 8'hAA,
    parameter logic [7:0]  SYNC1          = 8'h55,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          TIMEOUT_W      = 20
) (
    input  logic               clk,
    input  logic               rst,
    image_load_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LOAD,
        START,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0]    LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [ADDR_W-1:0]     pix_cnt;
    logic [TIMEOUT_W-1:0]  to_cnt;
    logic                  to_hit;
    logic                  waiting;

    assign waiting = (state == SYNC) || (state == LOAD);
    // Expiry only counts on a byte-less cycle, so a late byte always wins.
    assign to_hit  = waiting && !bus.rx_valid && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pix_cnt         <= '0;
            to_cnt          <= '0;
            bus.ram_wr_addr <= '0;
            bus.ram_wr_data <= '0;
            bus.ram_wr_en   <= 1'b0;
            bus.cnn_start   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.frame_count <= '0;
        end else begin
            bus.ram_wr_en   <= 1'b0;
            bus.cnn_start   <= 1'b0;
            bus.timeout_err <= 1'b0;

            if (bus.rx_valid || !waiting || to_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC0)
                        state <= SYNC;
                end
                SYNC: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == SYNC1) begin
                            state       <= LOAD;
                            pix_cnt     <= '0;
                            bus.overrun <= 1'b0;
                            bus.busy    <= 1'b1;
                        end else if (bus.rx_data != SYNC0) begin
                            state <= IDLE;
                        end
                    end else if (to_hit) begin
                        state           <= IDLE;
                        pix_cnt         <= '0;
                        bus.timeout_err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.rx_valid) begin
                        bus.ram_wr_en   <= 1'b1;
                        bus.ram_wr_addr <= pix_cnt;
                        bus.ram_wr_data <= bus.rx_data;
                        pix_cnt         <= pix_cnt + 1'b1;
                        if (pix_cnt == LAST_PIX)
                            state <= START;
                    end else if (to_hit) begin
                        state           <= IDLE;
                        pix_cnt         <= '0;
                        bus.busy        <= 1'b0;
                        bus.timeout_err <= 1'b1;
                    end
                end
                START: begin
                    // Start lands one cycle after the last RAM write commits.
                    bus.cnn_start <= 1'b1;
                    state         <= RUN;
                    if (bus.rx_valid)
                        bus.overrun <= 1'b1;
                end
                RUN: begin
                    if (bus.rx_valid)
                        bus.overrun <= 1'b1;
                    if (bus.cnn_done) begin
                        state           <= IDLE;
                        bus.busy        <= 1'b0;
                        bus.frame_count <= bus.frame_count + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_image_load_ctrl.sv
// Directed bench for image_load_ctrl: frames, sync handling,
// overrun, timeout and its race, reset mid-frame.
module tb_image_load_ctrl;
    localparam int NP = 784;
    localparam int AW = 10;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    image_load_ctrl_if #(.ADDR_W(AW)) bus ();

    image_load_ctrl #(
        .NUM_PIXELS    (NP),
        .ADDR_W        (AW),
        .SYNC0         (8'hAA),
        .SYNC1         (8'h55),
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_W     (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int to_cnt = 0;
    int log_addr [LOGN];
    int log_data [LOGN];
    int base;
    int base2;

    always @(negedge clk) begin
        if (bus.ram_wr_en === 1'b1) begin
            if (wr_cnt < LOGN) begin
                log_addr[wr_cnt] = int'(bus.ram_wr_addr);
                log_data[wr_cnt] = int'(bus.ram_wr_data);
            end
            wr_cnt++;
        end
        if (bus.cnn_start === 1'b1) start_cnt++;
        if (bus.timeout_err === 1'b1) to_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic done_pulse;
        bus.cnn_done = 1'b1;
        tick();
        bus.cnn_done = 1'b0;
    endtask

    task automatic load_frame(input int x);
        for (int k = 0; k < NP; k++) send(8'(k ^ x));
    endtask

    task automatic check_frame(input string tag, input int b, input int x);
        int bad;
        bad = 0;
        for (int k = 0; k < NP; k++) begin
            if (log_addr[b+k] != k || log_data[b+k] != ((k ^ x) & 255))
                bad++;
        end
        chk({tag, "_count"}, wr_cnt - b, NP);
        chk({tag, "_data"}, bad, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_wr_en"}, int'(bus.ram_wr_en), 0);
        chk({tag, "_addr"}, int'(bus.ram_wr_addr), 0);
        chk({tag, "_data"}, int'(bus.ram_wr_data), 0);
        chk({tag, "_start"}, int'(bus.cnn_start), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_overrun"}, int'(bus.overrun), 0);
        chk({tag, "_to_err"}, int'(bus.timeout_err), 0);
        chk({tag, "_fcount"}, int'(bus.frame_count), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.cnn_done = 1'b0;
        tick();
        tick();
        check_reset_outs("reset");
        rst = 1'b0;
        tick();

        // Frame 1: plain header, counting pattern
        send(8'hAA);
        send(8'h55);
        chk("f1_busy_load", int'(bus.busy), 1);
        base = wr_cnt;
        load_frame(0);
        chk("f1_start_n1", int'(bus.cnn_start), 0);
        chk("f1_last_wr_en", int'(bus.ram_wr_en), 1);
        chk("f1_last_addr", int'(bus.ram_wr_addr), NP - 1);
        tick();
        chk("f1_start_n2", int'(bus.cnn_start), 1);
        tick();
        chk("f1_start_n3", int'(bus.cnn_start), 0);
        chk("f1_start_cnt", start_cnt, 1);
        check_frame("f1", base, 0);

        // Overrun in RUN
        base = wr_cnt;
        send(8'hAA);
        send(8'h55);
        send(8'h07);
        tick();
        chk("ovr_no_write", wr_cnt - base, 0);
        chk("ovr_flag", int'(bus.overrun), 1);
        chk("ovr_busy_run", int'(bus.busy), 1);
        done_pulse();
        chk("f1_busy_done", int'(bus.busy), 0);
        chk("f1_fcount", int'(bus.frame_count), 1);

        // Frame 2: repeated SYNC0 in header
        send(8'hAA);
        send(8'hAA);
        send(8'h55);
        chk("f2_ovr_clr", int'(bus.overrun), 0);
        chk("f2_busy", int'(bus.busy), 1);
        base = wr_cnt;
        load_frame(8'h5A);
        tick();
        tick();
        check_frame("f2", base, 8'h5A);
        chk("f2_start_cnt", start_cnt, 2);
        done_pulse();
        chk("f2_fcount", int'(bus.frame_count), 2);

        // Spurious done in IDLE
        done_pulse();
        tick();
        chk("spur_done_fcount", int'(bus.frame_count), 2);

        // Broken header
        base = wr_cnt;
        send(8'hAA);
        send(8'h12);
        send(8'h55);
        send(8'h00);
        tick();
        chk("badhdr_no_write", wr_cnt - base, 0);
        chk("badhdr_busy", int'(bus.busy), 0);

        // Timeout after 100 pixels
        send(8'hAA);
        send(8'h55);
        base = wr_cnt;
        for (int k = 0; k < 100; k++) send(8'(k ^ 8'h33));
        repeat (15) tick();
        chk("to_not_yet", int'(bus.timeout_err), 0);
        chk("to_busy_held", int'(bus.busy), 1);
        tick();
        chk("to_pulse", int'(bus.timeout_err), 1);
        chk("to_busy_drop", int'(bus.busy), 0);
        tick();
        chk("to_pulse_end", int'(bus.timeout_err), 0);
        chk("to_count", to_cnt, 1);
        chk("to_writes", wr_cnt - base, 100);

        // Next frame restarts at 0; race byte on the 16th idle cycle
        send(8'hAA);
        send(8'h55);
        base2 = wr_cnt;
        for (int k = 0; k < 5; k++) send(8'(k + 8'h10));
        repeat (15) tick();
        send(8'hC5);
        chk("race_no_to", int'(bus.timeout_err), 0);
        chk("race_wr_en", int'(bus.ram_wr_en), 1);
        chk("race_addr", int'(bus.ram_wr_addr), 5);
        chk("race_data", int'(bus.ram_wr_data), 8'hC5);
        chk("after_to_addr0", log_addr[base2], 0);

        // Reset at pixel 400
        for (int k = 6; k < 400; k++) send(8'(k));
        chk("pre_rst_busy", int'(bus.busy), 1);
        chk("pre_rst_addr", int'(bus.ram_wr_addr), 399);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outs("midrst");
        chk("midrst_to_count", to_cnt, 1);

        // Fresh frame after reset
        send(8'hAA);
        send(8'h55);
        base = wr_cnt;
        load_frame(8'hC3);
        tick();
        tick();
        check_frame("f3", base, 8'hC3);
        chk("f3_start_cnt", start_cnt, 3);
        done_pulse();
        chk("f3_fcount", int'(bus.frame_count), 1);
        chk("f3_busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/image_load_ctrl.md
# image_load_ctrl

Sequencer between the UART byte receiver and the CNN inference engine. It frames the incoming pixel stream with a two-byte sync header and writes exactly 784 pixel bytes, in order, into the 784-byte image RAM (synchronous write, asynchronous read). When the image is complete it launches one inference and holds off new frames until the engine reports done.

## Interface
- NUM_PIXELS, 784, bytes per image; also the number of RAM writes per frame.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W ≥ NUM_PIXELS.
- SYNC0, 8'hAA, first header byte.
- SYNC1, 8'h55, second header byte.
- TIMEOUT_CYCLES, 1000000, number of idle cycles in SYNC/LOAD that aborts the frame; must be ≥ 2.
- TIMEOUT_W, 20, width of the timeout counter; must hold TIMEOUT_CYCLES.
- clk  in  1  system clock; the block uses only this clock.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe that qualifies rx_data.
- ram_wr_addr  out  ADDR_W  image RAM write address.
- ram_wr_data  out  8  image RAM write data.
- ram_wr_en  out  1  image RAM write enable.
- cnn_start  out  1  one-cycle pulse that starts inference.
- cnn_done  in  1  one-cycle pulse from the engine when inference finishes.
- busy  out  1  high in LOAD, START and RUN.
- overrun  out  1  sticky flag: a byte arrived during START or RUN and was dropped.
- timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout.
- frame_count  out  8  number of completed inferences; wraps from 255 to 0.

## Operation
- States: IDLE, SYNC, LOAD, START, RUN.
- IDLE:
  - rx_valid with rx_data==SYNC0 -> SYNC.
  - Any other byte is ignored.
- SYNC, on rx_valid:
  - SYNC1 -> LOAD; the pixel counter clears to 0.
  - SYNC0 -> stay in SYNC.
  - Any other byte -> IDLE.
- LOAD:
  - Each rx_valid writes rx_data to RAM at address = pixel counter, then increments the counter.
  - The write that lands at address NUM_PIXELS-1 moves the FSM to START.
  - Header values have no special meaning in LOAD; 0xAA and 0x55 are stored as ordinary pixels.
- START: cnn_start is high for this single cycle, then -> RUN.
- RUN:
  - cnn_done -> IDLE and frame_count increments.
  - cnn_done in any other state is ignored.
- overrun:
  - Set by rx_valid in START or RUN; the byte is not written.
  - Cleared by rst or by the SYNC->LOAD transition.
- Timeout:
  - The counter clears on every rx_valid and on every state change, and increments on other cycles in SYNC or LOAD.
  - On reaching TIMEOUT_CYCLES -> IDLE, with timeout_err high for one cycle and the pixel counter cleared.
  - If rx_valid arrives in the same cycle the counter would expire, rx_valid wins: the byte is processed normally and the counter clears.
  - RUN has no timeout.
- ram_wr_en is never asserted outside LOAD-accepted bytes; at most one write per rx_valid.
- Reset mid-frame: on the next edge, return to IDLE with all outputs at reset values. RAM contents are not cleared.

## Timing
- Reset values:
  - 0: ram_wr_addr, ram_wr_data, ram_wr_en, cnn_start, overrun, timeout_err, frame_count, busy.
  - State = IDLE.
- All outputs are registered.
- Write latency: rx_valid in LOAD at cycle n -> ram_wr_en=1 with the matching addr/data at cycle n+1, for exactly one cycle. The RAM commits the byte at the end of n+1.
- Final pixel (counter = NUM_PIXELS-1) accepted at cycle n:
  - Write visible at n+1, and the FSM is in START during n+1.
  - cnn_start=1 at n+2 only, so the engine's first read sees the complete image.
  - busy is high from the SYNC->LOAD edge through the cycle cnn_done is sampled; it falls the following cycle.
- Back-to-back rx_valid (every cycle) is supported at full rate.
- The earliest next frame is a SYNC0 byte in the cycle after the FSM returns to IDLE.

## Test plan
- Full frame: send AA 55 then bytes k&0xFF for k=0..783 -> 784 writes with addr k and data k&0xFF; one cnn_start 2 cycles after the last byte; after cnn_done, frame_count=1 and busy=0.
- Sync handling: send AA AA 55 then 784 bytes -> loads normally. Send AA 12 55 -> stays in IDLE with no writes.
- Overrun: send 3 bytes during RUN -> no ram_wr_en, overrun=1. A new AA 55 header clears it at the LOAD entry.
- Timeout with TIMEOUT_CYCLES=16: stall 16 cycles after 100 pixels -> timeout_err pulse, IDLE, busy=0. The next frame writes starting at addr 0.
- Timeout race: rx_valid in exactly the 16th idle cycle -> no timeout_err and the byte is written.
- rst during LOAD at pixel 400 -> all outputs 0 the next cycle, and a fresh frame loads from addr 0. Spurious cnn_done in IDLE -> frame_count unchanged.
